// File: rtl/alu_result_buffer.sv
// alu_result_buffer: registered output stage behind alu_comb.
// Captures valid ALU results (opcode, result, five flags) into a small FIFO
// and presents them to writeback via valid/ready. Also keeps sticky status
// flags and a saturating error counter for software/debug visibility.
module alu_result_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_opcode,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_zero,
    input  logic                     in_carry,
    input  logic                     in_overflow,
    input  logic                     in_negative,
    input  logic                     in_div_by_zero,
    input  logic                     in_sticky_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_opcode,
    output logic [WIDTH-1:0]         out_result,
    output logic [4:0]               out_flags,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic [4:0]               out_sticky,
    output logic [15:0]              out_err_count
);

    // Index width and pointer width; the extra pointer bit separates full
    // from empty when the index bits coincide.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] result;
        logic [4:0]       flags;   // {div_by_zero, negative, overflow, carry, zero}
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            err_hit;
    logic [4:0]      sticky;
    logic [4:0]      sticky_next;
    logic [15:0]     err_cnt;
    logic [15:0]     err_base;
    logic [15:0]     err_next;

    assign in_entry = '{opcode: in_opcode,
                        result: in_result,
                        flags:  {in_div_by_zero, in_negative, in_overflow, in_carry, in_zero}};

    // Status depends only on the registered pointers, so there is no
    // combinational path from out_ready to in_ready.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A full buffer refuses a push even when a pop happens the same cycle.
    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_count = wr_ptr - rd_ptr;

    // Show-ahead head read straight from storage; zeroed while empty so
    // stale storage never leaks out.
    assign head       = mem[rd_ptr[AW-1:0]];
    assign out_opcode = empty ? '0 : head.opcode;
    assign out_result = empty ? '0 : head.result;
    assign out_flags  = empty ? '0 : head.flags;

    assign out_sticky    = sticky;
    assign out_err_count = err_cnt;

    // Storage write at the tail; no reset needed, contents gated by pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_entry;
        end
    end

    // Head/tail pointers; reset discards all entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Next sticky / error-count values: clear first, then fold in the push.
    always_comb begin
        err_hit     = push && (in_overflow || in_div_by_zero);
        sticky_next = (in_sticky_clr ? 5'b0 : sticky) | (push ? in_entry.flags : 5'b0);
        err_base    = in_sticky_clr ? 16'h0 : err_cnt;
        err_next    = err_base;
        if (err_hit && (err_base != 16'hFFFF)) begin
            err_next = err_base + 16'h1;
        end
    end

    // Sticky flags and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky  <= '0;
            err_cnt <= '0;
        end else begin
            sticky  <= sticky_next;
            err_cnt <= err_next;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a queue scoreboard.
module tb_alu_result_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_opcode;
    logic [7:0]   in_result;
    logic         in_zero, in_carry, in_overflow, in_negative, in_div_by_zero;
    logic         in_sticky_clr;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_opcode;
    logic [7:0]   out_result;
    logic [4:0]   out_flags;
    logic [2:0]   out_count;
    logic [4:0]   out_sticky;
    logic [15:0]  out_err_count;

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_result(in_result),
        .in_zero(in_zero), .in_carry(in_carry), .in_overflow(in_overflow),
        .in_negative(in_negative), .in_div_by_zero(in_div_by_zero),
        .in_sticky_clr(in_sticky_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_result(out_result), .out_flags(out_flags),
        .out_count(out_count), .out_sticky(out_sticky), .out_err_count(out_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: {opcode, result, flags} in push order.
    logic [16:0] q[$];
    logic [4:0]  m_sticky;
    logic [15:0] m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at low phase, check head/ready before the edge,
    // update the model at the edge, check count/sticky/err after it.
    task automatic step(input logic v, input logic [3:0] op, input logic [7:0] res,
                        input logic [4:0] fl, input logic rdy, input logic clr);
        logic pu, po, ehit;
        logic [16:0] h;
        logic [15:0] eb;
        in_valid = v; in_opcode = op; in_result = res;
        {in_div_by_zero, in_negative, in_overflow, in_carry, in_zero} = fl;
        out_ready = rdy; in_sticky_clr = clr;
        #1;
        pu = v && (q.size() < DEPTH);
        po = rdy && (q.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            chk("out_opcode", 32'(out_opcode), 32'(h[16:13]));
            chk("out_result", 32'(out_result), 32'(h[12:5]));
            chk("out_flags", 32'(out_flags), 32'(h[4:0]));
        end else begin
            chk("empty_data", 32'({out_opcode, out_result, out_flags}), 32'h0);
        end
        @(posedge clk);
        if (po) void'(q.pop_front());
        if (pu) q.push_back({op, res, fl});
        m_sticky = (clr ? 5'b0 : m_sticky) | (pu ? fl : 5'b0);
        ehit = pu && (fl[2] || fl[4]);
        eb = clr ? 16'h0 : m_err;
        m_err = (ehit && eb != 16'hFFFF) ? eb + 16'h1 : eb;
        #1;
        chk("out_count", 32'(out_count), 32'(q.size()));
        chk("out_sticky", 32'(out_sticky), 32'(m_sticky));
        chk("out_err_count", 32'(out_err_count), 32'(m_err));
        @(negedge clk);
        in_valid = 1'b0; in_sticky_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_result = '0;
        in_zero = 0; in_carry = 0; in_overflow = 0; in_negative = 0; in_div_by_zero = 0;
        in_sticky_clr = 1'b0; out_ready = 1'b0;
        m_sticky = '0; m_err = '0;

        // Reset state
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(out_count), 32'h0);
        chk("rst_data", 32'({out_opcode, out_result, out_flags}), 32'h0);
        chk("rst_sticky", 32'(out_sticky), 32'h0);
        chk("rst_err", 32'(out_err_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, then drain
        step(1, 4'h0, 8'h05, 5'b00000, 0, 0);
        step(0, 4'h0, 8'h00, 5'b00000, 1, 0);
        step(0, 4'h0, 8'h00, 5'b00000, 0, 0);

        // Fill, overflow attempt dropped, drain in order
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 8'(i), 5'b00010, 0, 0);
        step(1, 4'hF, 8'h09, 5'b00001, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 4'h0, 8'h00, 5'b0, 1, 0);
        step(0, 4'h0, 8'h00, 5'b0, 1, 0);

        // Full with push+pop same cycle: pop only; next cycle push accepted
        for (int i = 5; i <= 8; i++) step(1, 4'h3, 8'(i), 5'b01000, 0, 0);
        step(1, 4'h7, 8'h0A, 5'b00000, 1, 0);
        step(1, 4'h7, 8'h0A, 5'b00000, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 4'h0, 8'h00, 5'b0, 1, 0);
        step(0, 4'h0, 8'h00, 5'b0, 0, 0);

        // Sticky flags and error counter
        step(0, 4'h0, 8'h00, 5'b0, 1, 1);
        step(1, 4'h2, 8'h7F, 5'b00100, 1, 0);
        step(1, 4'h5, 8'h00, 5'b10000, 1, 0);
        chk("sticky_acc", 32'(out_sticky), 32'h14);
        chk("err_two", 32'(out_err_count), 32'h2);
        step(1, 4'h1, 8'h00, 5'b00001, 1, 1);
        chk("sticky_clr_push", 32'(out_sticky), 32'h01);
        chk("err_clr", 32'(out_err_count), 32'h0);
        step(0, 4'h0, 8'h00, 5'b0, 1, 0);

        // Saturation: drive the counter to FFFF, then one more overflow push
        for (int i = 0; i < 65535; i++) step(1, 4'h2, 8'(i), 5'b00100, 1, 0);
        chk("err_at_max", 32'(out_err_count), 32'hFFFF);
        step(1, 4'h2, 8'hAA, 5'b00100, 1, 0);
        chk("err_saturated", 32'(out_err_count), 32'hFFFF);
        step(1, 4'h2, 8'hBB, 5'b10000, 1, 1);
        chk("err_clr_hit", 32'(out_err_count), 32'h1);
        step(0, 4'h0, 8'h00, 5'b0, 1, 0);

        // Asynchronous reset between edges while holding 3 entries
        for (int i = 0; i < 3; i++) step(1, 4'h6, 8'(8'h30 + i), 5'b01000, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_count", 32'(out_count), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        chk("arst_sticky", 32'(out_sticky), 32'h0);
        chk("arst_err", 32'(out_err_count), 32'h0);
        chk("arst_data", 32'({out_opcode, out_result, out_flags}), 32'h0);
        q.delete();
        m_sticky = '0; m_err = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4'h9, 8'h5A, 5'b00010, 0, 0);
        step(0, 4'h0, 8'h00, 5'b0, 1, 0);
        step(0, 4'h0, 8'h00, 5'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage downstream of the combinational ALU (`alu_comb`). Captures each valid ALU result, tagged with its opcode and five status flags, into a DEPTH-entry FIFO. Presents entries to the writeback consumer through a valid/ready handshake. Also keeps sticky status flags and a saturating error counter for software and debug visibility.

## Interface
- `WIDTH`, 8: ALU data width; must match the `alu_comb` instance.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  an ALU result is presented this cycle.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `in_opcode`  in  4  opcode that produced the result.
- `in_result`  in  WIDTH  ALU `out_result`.
- `in_zero`, `in_carry`, `in_overflow`, `in_negative`, `in_div_by_zero`  in  1 each  ALU flags.
- `in_sticky_clr`  in  1  synchronous clear of the sticky flags and the error counter.
- `out_valid`  out  1  head entry is available.
- `out_ready`  in  1  consumer takes the head entry.
- `out_opcode`  out  4  head opcode.
- `out_result`  out  WIDTH  head result.
- `out_flags`  out  5  head flags, ordered {div_by_zero, negative, overflow, carry, zero}.
- `out_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `out_sticky`  out  5  OR of flags over all accepted entries since the last clear; same bit order as `out_flags`.
- `out_err_count`  out  16  accepted entries with overflow=1 or div_by_zero=1; saturates at 16'hFFFF.

## Operation
- Push: occurs when `in_valid && in_ready`. Writes {opcode, result, flags} at the tail; the tail pointer increments mod DEPTH.
- Pop: occurs when `out_valid && out_ready`. The head pointer increments mod DEPTH.
- Pointers: each is $clog2(DEPTH)+1 bits; the extra bit distinguishes full from empty.
  - empty = pointers equal.
  - full = index bits equal and MSBs differ.
- Push and pop in the same cycle: both take effect, and `out_count` is unchanged.
- Full: `in_ready`=0, and a push is refused even if a pop happens in the same cycle. There is no pass-through.
- Empty: `out_valid`=0, and `out_opcode`, `out_result` and `out_flags` are forced to 0.
- Data outputs are show-ahead from storage at the head; no combinational path exists from the `in_*` data inputs.
- `in_valid` while `in_ready`=0: the data is ignored. The upstream stage must hold it; the buffer does not latch it.
- Sticky flags, per bit:
  - On a push: next = (`in_sticky_clr` ? 0 : sticky) | pushed flag.
  - No push: `in_sticky_clr` alone clears to 0.
  - Clear and push in the same cycle: the result equals the pushed flags.
- Error counter:
  - Increments on a push with overflow or div_by_zero set.
  - Holds at FFFF once saturated.
  - `in_sticky_clr` resets it to 0. With a simultaneous qualifying push it resets to 1.
- `out_count` = tail − head.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally). While `rst_n`=0:
  - `in_ready`=1.
  - `out_valid`=0, `out_count`=0.
  - `out_opcode`, `out_result`, `out_flags` = 0.
  - `out_sticky`=0, `out_err_count`=0.
  - Pointers = 0.
  - Storage contents are don't-care.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N appears on the `out_*` outputs with `out_valid`=1 after edge N. Minimum latency is 1 cycle.
- `in_ready` and `out_valid` are functions of registered pointers only. There is no combinational path from `out_ready` to `in_ready`.
- Sustained throughput is one entry per cycle when `out_ready`=1.
- Sticky and counter updates are visible the cycle after the push.

## Test plan
- Reset, then a push with opcode=0, result=8'h05, flags=5'b00000 and `out_ready`=0 → `out_valid`=1, `out_result`=05, `out_count`=1, `in_ready`=1.
- Push 4 entries with results 1,2,3,4 and `out_ready`=0 → `in_ready`=0, `out_count`=4. A 5th push (result 9) is dropped. Then pop 4 with `out_ready`=1 → outputs 1,2,3,4 in order, followed by `out_valid`=0 with `out_result`=0.
- Full buffer with `in_valid`=1 and `out_ready`=1 in the same cycle → one pop, no push, `out_count`=3. The following cycle the push is accepted, `out_count`=3, and wrap-around order is preserved.
- Push flags 5'b00100 (overflow), then 5'b10000 (div0) → `out_sticky`=10100, `out_err_count`=2. Then `in_sticky_clr` together with a push of flags 00001 → `out_sticky`=00001, `out_err_count`=0.
- Force the counter to FFFF and push an overflow entry → the counter stays FFFF.
- Assert `rst_n`=0 asynchronously while 3 entries are held, between clock edges → `out_valid`=0 and `out_count`=0 immediately. After release, a push is accepted normally.
